crc_serial_param: RTL and testbench

Parametrised serial CRC engine: computes a CRC_W-bit LFSR CRC over a bit-serial frame of any length framed by ACTIVE, then shifts the CRC out LSB-first with VALID. Successor to the fixed 8-bit serial CRC in the link layer, adding configurable width, polynomial and seed, a BUSY indication, and an optional receive-side check mode. Sits between the serialiser and the line driver on TX, and after the deserialiser on RX.

---
 rtl/crc_pkg.sv | 28 ++
 rtl/crc_lfsr.sv | 46 ++++
 rtl/crc_serial_param.sv | 157 +++++++++++++++
 tb/tb_crc_serial_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and constants for the parametrised serial CRC engine.
// Check mode is enabled by defining CRC_CHECK_EN.
package crc_pkg;

  // Top-level frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SHIFT = 2'd2
  } crc_state_e;

  // Operations applied to the LFSR register each cycle
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STEP  = 2'd2,
    OP_SHIFT = 2'd3
  } lfsr_op_e;

  localparam logic [7:0] DEF_POLY = 8'h44;
  localparam logic [7:0] DEF_SEED = 8'hD8;

  // Width of a counter that must hold the values 0..crc_w inclusive
  function automatic int cnt_width(input int crc_w);
    return $clog2(crc_w + 1);
  endfunction

endpackage

// File: rtl/crc_lfsr.sv
// CRC LFSR register: reload to seed, step with a data bit, or shift out.
module crc_lfsr
  import crc_pkg::*;
#(
  parameter int                 CRC_W = 8,
  parameter logic [CRC_W-1:0]   POLY  = CRC_W'(DEF_POLY),
  parameter logic [CRC_W-1:0]   SEED  = CRC_W'(DEF_SEED)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  lfsr_op_e         i_op,
  input  logic             i_data,
  output logic [CRC_W-1:0] o_lfsr
);

  // The top bit always takes feedback regardless of POLY's top bit.
  localparam logic [CRC_W-1:0] TAPS = {1'b1, {(CRC_W-1){1'b0}}} | POLY;

  logic [CRC_W-1:0] r_lfsr;
  logic [CRC_W-1:0] w_lfsr_nxt;
  logic             w_fb;

  // Next LFSR value for the requested operation
  always_comb begin
    w_fb       = i_data ^ r_lfsr[0];
    w_lfsr_nxt = r_lfsr;
    case (i_op)
      OP_LOAD:  w_lfsr_nxt = SEED;
      OP_STEP:  w_lfsr_nxt = (r_lfsr >> 1) ^ (w_fb ? TAPS : {CRC_W{1'b0}});
      OP_SHIFT: w_lfsr_nxt = r_lfsr >> 1;
      default:  w_lfsr_nxt = r_lfsr;
    endcase
  end

  // LFSR state register, seeded on reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= w_lfsr_nxt;
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/crc_serial_param.sv
// Serial CRC engine: accumulates a frame framed by i_active, then shifts the
// CRC out LSB-first. Defining CRC_CHECK_EN adds i_mode/o_err and check mode.
module crc_serial_param
  import crc_pkg::*;
#(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(DEF_POLY),
  parameter logic [CRC_W-1:0] SEED  = CRC_W'(DEF_SEED)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_data,
`ifdef CRC_CHECK_EN
  input  logic i_mode,
  output logic o_err,
`endif
  output logic o_crc,
  output logic o_valid,
  output logic o_busy
);

  localparam int CW = cnt_width(CRC_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(CRC_W);

  crc_state_e       r_state, w_state_nxt;
  lfsr_op_e         w_op;
  logic [CRC_W-1:0] w_lfsr;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_crc, w_crc_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_check;

`ifdef CRC_CHECK_EN
  logic r_mode, w_mode_nxt;
  logic r_err, w_err_nxt;
  assign w_check = r_mode;
`else
  assign w_check = 1'b0;
`endif

  crc_lfsr #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_op   (w_op),
    .i_data (i_data),
    .o_lfsr (w_lfsr)
  );

  // Frame sequencing: next state, LFSR operation, counter and output values
  always_comb begin
    w_state_nxt = r_state;
    w_op        = OP_HOLD;
    w_cnt_nxt   = r_cnt;
    w_crc_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
`ifdef CRC_CHECK_EN
    w_mode_nxt  = r_mode;
    w_err_nxt   = r_err;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_active) begin
          w_op        = OP_STEP;
          w_state_nxt = ST_ACCUM;
`ifdef CRC_CHECK_EN
          w_mode_nxt  = i_mode;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (i_active) begin
          w_op = OP_STEP;
        end else if (w_check) begin
          // Check-mode frame end: a correct frame leaves a zero remainder.
          w_state_nxt = ST_IDLE;
          w_op        = OP_LOAD;
          w_valid_nxt = 1'b1;
`ifdef CRC_CHECK_EN
          w_err_nxt   = |w_lfsr;
`endif
        end else begin
          // Generate-mode frame end: first CRC bit goes out on this edge.
          w_state_nxt = ST_SHIFT;
          w_op        = OP_SHIFT;
          w_crc_nxt   = w_lfsr[0];
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_op        = OP_LOAD;
          w_cnt_nxt   = {CW{1'b0}};
        end else begin
          w_op        = OP_SHIFT;
          w_crc_nxt   = w_lfsr[0];
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_op        = OP_LOAD;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_crc   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_crc   <= w_crc_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

`ifdef CRC_CHECK_EN
  // Latched frame mode and held check result
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign o_err = r_err;
`endif

  assign o_crc   = r_crc;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_crc_serial_param.sv
// Self-checking bench for crc_serial_param (default parameters).
module tb_crc_serial_param;

  localparam int         CRC_W = 8;
  localparam logic [7:0] SEED  = 8'hD8;
  localparam logic [7:0] TAPS  = 8'h80 | 8'h44;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_active = 1'b0;
  logic i_data = 1'b0;
  logic o_crc, o_valid, o_busy;
`ifdef CRC_CHECK_EN
  logic i_mode = 1'b0;
  logic o_err;
`endif

  int n_pass  = 0;
  int n_total = 0;

  crc_serial_param dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_active (i_active),
    .i_data   (i_data),
`ifdef CRC_CHECK_EN
    .i_mode   (i_mode),
    .o_err    (o_err),
`endif
    .o_crc    (o_crc),
    .o_valid  (o_valid),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Reference: CRC of a bit sequence (bit 0 first) by the feedback rule
  function automatic logic [7:0] model_crc(input logic [127:0] bits, input int n);
    logic [7:0] r;
    r = SEED;
    for (int i = 0; i < n; i++) begin
      if ((bits[i] ^ r[0]) == 1'b1) r = (r >> 1) ^ TAPS;
      else                          r = r >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bits(input logic [127:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      i_active = 1'b1;
      i_data   = bits[i];
      @(posedge i_clk); #1;
      chk("accum_busy", 32'(o_busy), 32'd0);
    end
    i_active = 1'b0;
    i_data   = 1'b0;
  endtask

  // Generate-mode frame; collects the serial CRC and checks framing
  task automatic gen_frame(input string tag, input logic [127:0] bits, input int n,
                           input bit noise, output logic [7:0] got);
    logic [7:0] exp;
    exp = model_crc(bits, n);
    got = 8'h00;
    drive_bits(bits, n);
    for (int k = 0; k <= CRC_W; k++) begin
      @(posedge i_clk); #1;
      if (k < CRC_W) begin
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_busy"},  32'(o_busy),  32'd1);
        got[k] = o_crc;
      end else begin
        chk({tag, "_valid_end"}, 32'(o_valid), 32'd0);
        chk({tag, "_busy_end"},  32'(o_busy),  32'd0);
        chk({tag, "_crc_end"},   32'(o_crc),   32'd0);
      end
      if (noise && k < CRC_W) begin
        i_active = 1'($urandom_range(0, 1));
        i_data   = 1'($urandom_range(0, 1));
      end else begin
        i_active = 1'b0;
        i_data   = 1'b0;
      end
    end
    chk({tag, "_crc"}, 32'(got), 32'(exp));
  endtask

`ifdef CRC_CHECK_EN
  // Check-mode frame; MODE is dropped after the first bit to test latching
  task automatic chk_frame(input string tag, input logic [127:0] bits, input int n,
                           input logic exp_err);
    i_mode = 1'b1;
    for (int i = 0; i < n; i++) begin
      i_active = 1'b1;
      i_data   = bits[i];
      @(posedge i_clk); #1;
      i_mode = 1'b0;
    end
    i_active = 1'b0;
    @(posedge i_clk); #1;
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_err"},   32'(o_err),   32'(exp_err));
    chk({tag, "_busy"},  32'(o_busy),  32'd0);
    @(posedge i_clk); #1;
    chk({tag, "_valid_off"}, 32'(o_valid), 32'd0);
    chk({tag, "_err_hold"},  32'(o_err),   32'(exp_err));
  endtask
`endif

  initial begin
    logic [7:0]   got;
    logic [127:0] bits;
    int           n;

    // Reset state
    #2;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_crc",   32'(o_crc),   32'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Known frames from the defaults
    gen_frame("f00", 128'h00, 8, 1'b0, got);
    chk("f00_const", 32'(got), 32'h14);
    gen_frame("fff", 128'hFF, 8, 1'b0, got);
    chk("fff_const", 32'(got), 32'h72);
    gen_frame("b2b", 128'h00, 8, 1'b0, got);
    chk("b2b_const", 32'(got), 32'h14);

    // ACTIVE/DATA toggled during SHIFT are ignored
    gen_frame("noise", 128'h00, 8, 1'b1, got);
    chk("noise_const", 32'(got), 32'h14);
    gen_frame("after_noise", 128'hFF, 8, 1'b0, got);
    chk("after_noise_const", 32'(got), 32'h72);

    // Reset at bit 4 of a frame
    for (int i = 0; i < 4; i++) begin
      i_active = 1'b1; i_data = 1'b1;
      @(posedge i_clk); #1;
    end
    i_rst = 1'b1; #1;
    chk("rstf_valid", 32'(o_valid), 32'd0);
    chk("rstf_busy",  32'(o_busy),  32'd0);
    chk("rstf_crc",   32'(o_crc),   32'd0);
    i_active = 1'b0; i_data = 1'b0;
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(posedge i_clk); #1;
    gen_frame("post_rstf", 128'hFF, 8, 1'b0, got);
    chk("post_rstf_const", 32'(got), 32'h72);

    // Reset in the middle of the shift-out
    drive_bits(128'hFF, 8);
    repeat (3) @(posedge i_clk);
    #3;
    chk("rsts_valid_pre", 32'(o_valid), 32'd1);
    i_rst = 1'b1; #1;
    chk("rsts_valid", 32'(o_valid), 32'd0);
    chk("rsts_busy",  32'(o_busy),  32'd0);
    chk("rsts_crc",   32'(o_crc),   32'd0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(posedge i_clk); #1;
    gen_frame("post_rsts", 128'h00, 8, 1'b0, got);
    chk("post_rsts_const", 32'(got), 32'h14);

    // Randomised frames of varied length
    for (int t = 0; t < 20; t++) begin
      bits = {$urandom, $urandom, $urandom, $urandom};
      n    = int'($urandom_range(1, 40));
      gen_frame("rand", bits, n, (t % 3) == 0, got);
    end

    // Zero-length frames: nothing happens while ACTIVE stays low
    for (int c = 0; c < 30; c++) begin
      i_active = 1'b0;
      i_data   = 1'($urandom_range(0, 1));
      @(posedge i_clk); #1;
      chk("idle_valid", 32'(o_valid), 32'd0);
      chk("idle_busy",  32'(o_busy),  32'd0);
      chk("idle_crc",   32'(o_crc),   32'd0);
    end
    i_data = 1'b0;

`ifdef CRC_CHECK_EN
    chk_frame("chk_ok",  {112'h0, 8'h14, 8'h00}, 16, 1'b0);
    chk_frame("chk_bad", {112'h0, 8'h15, 8'h00}, 16, 1'b1);
    for (int t = 0; t < 8; t++) begin
      n    = int'($urandom_range(1, 40));
      bits = {$urandom, $urandom, $urandom, $urandom};
      for (int j = n; j < 128; j++) bits[j] = 1'b0;
      got  = model_crc(bits, n);
      for (int j = 0; j < CRC_W; j++) bits[n + j] = got[j];
      chk_frame("chk_rand_ok", bits, n + CRC_W, 1'b0);
      bits[$urandom_range(0, n + CRC_W - 1)] ^= 1'b1;
      chk_frame("chk_rand_bad", bits, n + CRC_W, 1'b1);
    end
    i_mode = 1'b0;
    gen_frame("gen_after_chk", 128'h00, 8, 1'b0, got);
    chk("gen_after_chk_const", 32'(got), 32'h14);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
